// File: rtl/oserdes_burst_ctl.sv
`default_nettype none
// ============================================================================
// Module   : oserdes_burst_ctl
// Purpose  : DDR3 write-burst controller for the divided-clock domain. It takes
//            one burst request plus a write-data stream and produces per-lane
//            serializer data/tristate words for DQ and DQS. The sequence is
//            write latency, DQS preamble, data, then DQS postamble.
// Ports    : clk, rst        - divided serializer clock, sync active-high reset
//            wr_start        - burst request pulse (wlat/burst_len sampled with it)
//            wlat, burst_len - write latency / number of data cycles
//            din, din_rdy    - write data stream, consumed when din_rdy=1
//            dq_out, dq_tri  - DQ serializer data / tristate words (1 = high-Z)
//            dqs_out, dqs_tri- DQS serializer data / tristate words
//            busy, err       - burst in progress / rejected-request pulse
// Options  : OSERDES_BURST_POSTAMBLE_EN - when defined, the DQS postamble state
//            runs for POST_CYCLES; otherwise DATA returns straight to IDLE.
// Revision : 1.0 - initial release
// ============================================================================
module oserdes_burst_ctl #(
    parameter int NLANES      = 8,
    parameter int DATA_WIDTH  = 4,
    parameter int PRE_CYCLES  = 1,
    parameter int POST_CYCLES = 1,
    parameter int LAT_BITS    = 4,
    parameter int LEN_BITS    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_start,
    input  logic [LAT_BITS-1:0]          wlat,
    input  logic [LEN_BITS-1:0]          burst_len,
    input  logic [NLANES*DATA_WIDTH-1:0] din,
    output logic                         din_rdy,
    output logic [NLANES*DATA_WIDTH-1:0] dq_out,
    output logic [NLANES*DATA_WIDTH-1:0] dq_tri,
    output logic [DATA_WIDTH-1:0]        dqs_out,
    output logic [DATA_WIDTH-1:0]        dqs_tri,
    output logic                         busy,
    output logic                         err
);

    localparam int c_dq_w = NLANES * DATA_WIDTH;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_wait = 3'd1;
    localparam logic [2:0] c_st_pre  = 3'd2;
    localparam logic [2:0] c_st_data = 3'd3;
    localparam logic [2:0] c_st_post = 3'd4;

    // Even bits high, odd bits low: bit 0 is serialized first, so DQS starts high.
    localparam logic [DATA_WIDTH-1:0] c_dqs_toggle = {(DATA_WIDTH/2){2'b01}};
    localparam logic [31:0]           c_pre_cycles = PRE_CYCLES;
`ifdef OSERDES_BURST_POSTAMBLE_EN
    localparam logic [1:0]            c_post_last  = 2'(POST_CYCLES - 1);
`endif

    logic [2:0]          r_state, w_state_nxt;
    logic [LAT_BITS-1:0] r_lat_cnt, w_lat_cnt_nxt;   // remaining WAIT/PRE cycles after this one
    logic [LEN_BITS-1:0] r_data_cnt, w_data_cnt_nxt; // remaining DATA cycles after this one
    logic [LAT_BITS-1:0] r_pre_len, w_pre_len_nxt;
    logic [LEN_BITS-1:0] r_len, w_len_nxt;
`ifdef OSERDES_BURST_POSTAMBLE_EN
    logic [1:0]          r_post_cnt, w_post_cnt_nxt;
`endif

    logic [LAT_BITS-1:0] w_lat_eff;
    logic [LAT_BITS-1:0] w_pre_eff;
    logic [LAT_BITS-1:0] w_wait_len;
    logic                w_rdy_nxt;

    logic                r_din_rdy;
    logic [c_dq_w-1:0]   r_dq_out;
    logic [c_dq_w-1:0]   r_dq_tri;
    logic [DATA_WIDTH-1:0] r_dqs_out;
    logic [DATA_WIDTH-1:0] r_dqs_tri;
    logic                r_busy;
    logic                r_err;

    // L = max(wlat,1); P = min(PRE_CYCLES, L). The comparison is done at 32 bits
    // so a narrow LAT_BITS cannot truncate PRE_CYCLES before the min.
    assign w_lat_eff  = (wlat == '0) ? LAT_BITS'(1) : wlat;
    assign w_pre_eff  = ({{(32-LAT_BITS){1'b0}}, w_lat_eff} > c_pre_cycles)
                        ? LAT_BITS'(PRE_CYCLES) : w_lat_eff;
    assign w_wait_len = w_lat_eff - w_pre_eff;

    always_comb begin
        w_state_nxt    = r_state;
        w_lat_cnt_nxt  = r_lat_cnt;
        w_data_cnt_nxt = r_data_cnt;
        w_pre_len_nxt  = r_pre_len;
        w_len_nxt      = r_len;
`ifdef OSERDES_BURST_POSTAMBLE_EN
        w_post_cnt_nxt = r_post_cnt;
`endif
        case (r_state)
            c_st_idle: begin
                if (wr_start && (burst_len != '0)) begin
                    w_len_nxt     = burst_len;
                    w_pre_len_nxt = w_pre_eff;
                    // When P == L the preamble begins in the very first cycle,
                    // so the WAIT phase is zero length and skipped.
                    if (w_wait_len != '0) begin
                        w_state_nxt   = c_st_wait;
                        w_lat_cnt_nxt = w_wait_len - LAT_BITS'(1);
                    end else begin
                        w_state_nxt   = c_st_pre;
                        w_lat_cnt_nxt = w_pre_eff - LAT_BITS'(1);
                    end
                end
            end
            c_st_wait: begin
                if (r_lat_cnt == '0) begin
                    w_state_nxt   = c_st_pre;
                    w_lat_cnt_nxt = r_pre_len - LAT_BITS'(1);
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt - LAT_BITS'(1);
                end
            end
            c_st_pre: begin
                if (r_lat_cnt == '0) begin
                    w_state_nxt    = c_st_data;
                    w_data_cnt_nxt = r_len - LEN_BITS'(1);
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt - LAT_BITS'(1);
                end
            end
            c_st_data: begin
                if (r_data_cnt == '0) begin
`ifdef OSERDES_BURST_POSTAMBLE_EN
                    w_state_nxt    = c_st_post;
                    w_post_cnt_nxt = c_post_last;
`else
                    w_state_nxt    = c_st_idle;
`endif
                end else begin
                    w_data_cnt_nxt = r_data_cnt - LEN_BITS'(1);
                end
            end
            c_st_post: begin
`ifdef OSERDES_BURST_POSTAMBLE_EN
                if (r_post_cnt == 2'd0) begin
                    w_state_nxt = c_st_idle;
                end else begin
                    w_post_cnt_nxt = r_post_cnt - 2'd1;
                end
`else
                w_state_nxt = c_st_idle;
`endif
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // din is requested in the last preamble cycle and every data cycle but the
    // last, so that each word lands on dq_out one cycle later during DATA.
    assign w_rdy_nxt = ((w_state_nxt == c_st_pre)  && (w_lat_cnt_nxt  == '0)) ||
                       ((w_state_nxt == c_st_data) && (w_data_cnt_nxt != '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_lat_cnt  <= '0;
            r_data_cnt <= '0;
            r_pre_len  <= '0;
            r_len      <= '0;
`ifdef OSERDES_BURST_POSTAMBLE_EN
            r_post_cnt <= 2'd0;
`endif
            r_din_rdy  <= 1'b0;
            r_dq_out   <= '0;
            r_dq_tri   <= '1;
            r_dqs_out  <= '0;
            r_dqs_tri  <= '1;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lat_cnt  <= w_lat_cnt_nxt;
            r_data_cnt <= w_data_cnt_nxt;
            r_pre_len  <= w_pre_len_nxt;
            r_len      <= w_len_nxt;
`ifdef OSERDES_BURST_POSTAMBLE_EN
            r_post_cnt <= w_post_cnt_nxt;
`endif
            r_din_rdy  <= w_rdy_nxt;
            r_busy     <= (w_state_nxt != c_st_idle);
            r_err      <= wr_start && ((r_state != c_st_idle) || (burst_len == '0));
            // A word consumed at this edge is driven during the next cycle.
            r_dq_out   <= r_din_rdy ? din : '0;
            r_dq_tri   <= r_din_rdy ? '0 : '1;
            case (w_state_nxt)
                c_st_pre, c_st_post: begin
                    r_dqs_out <= '0;
                    r_dqs_tri <= '0;
                end
                c_st_data: begin
                    r_dqs_out <= c_dqs_toggle;
                    r_dqs_tri <= '0;
                end
                default: begin
                    r_dqs_out <= '0;
                    r_dqs_tri <= '1;
                end
            endcase
        end
    end

    assign din_rdy = r_din_rdy;
    assign dq_out  = r_dq_out;
    assign dq_tri  = r_dq_tri;
    assign dqs_out = r_dqs_out;
    assign dqs_tri = r_dqs_tri;
    assign busy    = r_busy;
    assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_oserdes_burst_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_oserdes_burst_ctl
// Purpose  : Directed self-checking bench for oserdes_burst_ctl. Two instances
//            share all inputs: one with PRE_CYCLES=1, one with PRE_CYCLES=2.
//            Cycle 0 is the cycle in which wr_start is presented; expected
//            values for cycle k follow the burst timeline for L, P, burst_len.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oserdes_burst_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_start;
    logic [3:0]  wlat;
    logic [3:0]  burst_len;
    logic [31:0] din;

    logic        din_rdy_a, busy_a, err_a;
    logic [31:0] dq_out_a, dq_tri_a;
    logic [3:0]  dqs_out_a, dqs_tri_a;
    logic        din_rdy_b, busy_b, err_b;
    logic [31:0] dq_out_b, dq_tri_b;
    logic [3:0]  dqs_out_b, dqs_tri_b;

    logic [31:0] tab [16];
    int          n_vec = 0;
    int          n_err = 0;
`ifdef OSERDES_BURST_POSTAMBLE_EN
    localparam int c_post = 1;
`else
    localparam int c_post = 0;
`endif

    always #5 clk = ~clk;

    oserdes_burst_ctl #(.NLANES(8), .DATA_WIDTH(4), .PRE_CYCLES(1), .POST_CYCLES(1),
                        .LAT_BITS(4), .LEN_BITS(4)) u_dut_a (
        .clk(clk), .rst(rst), .wr_start(wr_start), .wlat(wlat), .burst_len(burst_len),
        .din(din), .din_rdy(din_rdy_a), .dq_out(dq_out_a), .dq_tri(dq_tri_a),
        .dqs_out(dqs_out_a), .dqs_tri(dqs_tri_a), .busy(busy_a), .err(err_a));

    oserdes_burst_ctl #(.NLANES(8), .DATA_WIDTH(4), .PRE_CYCLES(2), .POST_CYCLES(1),
                        .LAT_BITS(4), .LEN_BITS(4)) u_dut_b (
        .clk(clk), .rst(rst), .wr_start(wr_start), .wlat(wlat), .burst_len(burst_len),
        .din(din), .din_rdy(din_rdy_b), .dq_out(dq_out_b), .dq_tri(dq_tri_b),
        .dqs_out(dqs_out_b), .dqs_tri(dqs_tri_b), .busy(busy_b), .err(err_b));

    task automatic chk(input string tag, input int cyc, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
        end
    endtask

    // {dqs_out, dqs_tri} for cycle k of a burst with latency L, preamble P.
    function automatic logic [7:0] dqs_exp(input int k, input int L, input int P,
                                           input int len);
        bit pre, dat, pst;
        pre = (k >= L - P + 1) && (k <= L);
        dat = (k >= L + 1) && (k <= L + len);
        pst = (k >= L + len + 1) && (k <= L + len + c_post);
        if (dat)              return {4'b0101, 4'b0000};
        else if (pre || pst)  return {4'b0000, 4'b0000};
        else                  return {4'b0000, 4'b1111};
    endfunction

    // Checks the idle/reset output values of both instances.
    task automatic chk_idle(input string tag, input int cyc, input logic e_err);
        chk({tag, "_ctl_a"}, cyc, {61'd0, din_rdy_a, busy_a, err_a}, {61'd0, 1'b0, 1'b0, e_err});
        chk({tag, "_ctl_b"}, cyc, {61'd0, din_rdy_b, busy_b, err_b}, {61'd0, 1'b0, 1'b0, e_err});
        chk({tag, "_dq"},    cyc, {dq_out_a, dq_tri_a}, {32'h0, 32'hFFFF_FFFF});
        chk({tag, "_dqs_a"}, cyc, {56'd0, dqs_out_a, dqs_tri_a}, {56'd0, 8'h0F});
        chk({tag, "_dqs_b"}, cyc, {56'd0, dqs_out_b, dqs_tri_b}, {56'd0, 8'h0F});
    endtask

    // Runs one burst from cycle 0. extra_at >= 0 presents a second wr_start
    // while busy; rst_at >= 0 asserts reset during that cycle.
    task automatic run_burst(input int wlat_i, input int len_i, input int extra_at,
                             input int rst_at);
        int L, pa, pb, last, kmax;
        logic [2:0]  e_ctl;
        logic [31:0] e_dq, e_tri;
        L    = (wlat_i == 0) ? 1 : wlat_i;
        pa   = (1 < L) ? 1 : L;
        pb   = (2 < L) ? 2 : L;
        last = L + len_i + c_post;
        kmax = (rst_at >= 0) ? rst_at + 2 : last + 1;
        for (int k = 0; k <= kmax; k++) begin
            wr_start  = (k == 0) || (k == extra_at);
            wlat      = 4'(wlat_i);
            burst_len = 4'(len_i);
            rst       = (k == rst_at);
            din       = (k >= L && k < L + len_i) ? tab[k - L] : (32'hA5C3_0000 | 32'(k));
            @(negedge clk);
            if (rst_at >= 0 && k > rst_at) begin
                chk_idle("rst", k, 1'b0);
            end else begin
                e_ctl[2] = (k >= L) && (k <= L + len_i - 1);
                e_ctl[1] = (k >= 1) && (k <= last);
                e_ctl[0] = (extra_at >= 0) && (k == extra_at + 1);
                if (k >= L + 1 && k <= L + len_i) begin
                    e_dq  = tab[k - L - 1];
                    e_tri = 32'h0;
                end else begin
                    e_dq  = 32'h0;
                    e_tri = 32'hFFFF_FFFF;
                end
                chk("ctl_a", k, {61'd0, din_rdy_a, busy_a, err_a}, {61'd0, e_ctl});
                chk("ctl_b", k, {61'd0, din_rdy_b, busy_b, err_b}, {61'd0, e_ctl});
                chk("dq_a",  k, {dq_out_a, dq_tri_a}, {e_dq, e_tri});
                chk("dq_b",  k, {dq_out_b, dq_tri_b}, {e_dq, e_tri});
                chk("dqs_a", k, {56'd0, dqs_out_a, dqs_tri_a}, {56'd0, dqs_exp(k, L, pa, len_i)});
                chk("dqs_b", k, {56'd0, dqs_out_b, dqs_tri_b}, {56'd0, dqs_exp(k, L, pb, len_i)});
            end
            @(posedge clk);
            #1;
        end
        wr_start = 1'b0;
        rst      = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_start = 1'b0; wlat = 4'd0; burst_len = 4'd0; din = 32'h0;
        for (int i = 0; i < 16; i++) tab[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk_idle("reset", 0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Baseline: wlat=3, burst_len=2.
        tab[0] = 32'h1111_1111; tab[1] = 32'h2222_2222;
        run_burst(3, 2, -1, -1);

        // wlat=0 -> L=1, P=1 for both instances.
        tab[0] = 32'hCAFE_F00D;
        run_burst(0, 1, -1, -1);

        // wlat=2 -> instance B has a two-cycle preamble starting in cycle 1.
        tab[0] = 32'h0123_4567; tab[1] = 32'h89AB_CDEF; tab[2] = 32'hFEDC_BA98;
        run_burst(2, 3, -1, -1);

        // Request while busy is rejected with a single err pulse.
        tab[0] = 32'h1111_1111; tab[1] = 32'h2222_2222;
        run_burst(3, 2, 2, -1);

        // Request with burst_len=0 is rejected.
        wr_start = 1'b1; wlat = 4'd3; burst_len = 4'd0;
        @(negedge clk);
        chk_idle("len0_c0", 0, 1'b0);
        @(posedge clk);
        #1;
        wr_start = 1'b0;
        @(negedge clk);
        chk_idle("len0_c1", 1, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_idle("len0_c2", 2, 1'b0);
        @(posedge clk);
        #1;

        // rst together with wr_start: reset wins, no err.
        rst = 1'b1; wr_start = 1'b1; burst_len = 4'd2;
        @(posedge clk);
        #1;
        rst = 1'b0; wr_start = 1'b0;
        @(negedge clk);
        chk_idle("rst_start", 1, 1'b0);
        @(posedge clk);
        #1;

        // Reset mid-burst in cycle 4, then a fresh burst is accepted.
        run_burst(3, 2, -1, 4);
        run_burst(3, 2, -1, -1);

        // Longest burst with walking-one data across the lanes.
        for (int i = 0; i < 15; i++) tab[i] = 32'h1 << (2 * i + 1);
        run_burst(15, 15, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=0 got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/oserdes_burst_ctl.md
# oserdes_burst_ctl

Parametrised multi-lane write-burst controller that drives the parallel inputs of the DDR3 output serializers. It runs in the divided-clock domain and turns a single burst request plus a write-data stream into per-lane serializer data/tristate words for DQ and DQS. It sequences write latency, DQS preamble, data and postamble with a cycle-exact state machine. It sits between the memory sequencer and the per-pin serializer wrappers.

## Interface
Parameters:
- NLANES, 8, number of DQ lanes (bits) driven.
- DATA_WIDTH, 4, serializer parallel width per lane per clk: 2, 4 or 8.
- PRE_CYCLES, 1, DQS preamble length in clk cycles (1..3).
- POST_CYCLES, 1, DQS postamble length in clk cycles (1..3).
- LAT_BITS, 4, width of the write-latency field.
- LEN_BITS, 4, width of the burst-length field.

Ports:
- clk, in, 1, divided serializer clock; sole clock.
- rst, in, 1, reset; synchronous, active-high.
- wr_start, in, 1, burst request pulse.
- wlat, in, LAT_BITS, write latency in clk cycles; sampled with wr_start.
- burst_len, in, LEN_BITS, data cycles in the burst; sampled with wr_start.
- din, in, NLANES*DATA_WIDTH, write data. Lane n occupies bits [n*DATA_WIDTH +: DATA_WIDTH]; bit 0 is serialized first.
- din_rdy, out, 1, din is consumed at this cycle's edge.
- dq_out, out, NLANES*DATA_WIDTH, serializer data words.
- dq_tri, out, NLANES*DATA_WIDTH, serializer tristate words; 1 means high-Z.
- dqs_out, out, DATA_WIDTH, DQS data word.
- dqs_tri, out, DATA_WIDTH, DQS tristate word; all bits are always equal.
- busy, out, 1, a burst is in progress.
- err, out, 1, one-cycle pulse when a request is rejected.

## Operation
- FSM states: IDLE, WAIT, PRE, DATA, POST.
  - IDLE to WAIT on an accepted wr_start.
  - WAIT to PRE when the latency count reaches the preamble start.
  - PRE to DATA after the effective preamble length.
  - DATA to POST after burst_len cycles.
  - POST to IDLE after POST_CYCLES.
- Acceptance: wr_start is accepted only when busy=0 and burst_len≠0. Otherwise it is ignored and err pulses for 1 cycle in the next cycle.
- Effective latency: L = max(wlat,1).
- Effective preamble: P = min(PRE_CYCLES, L).
- Timeline, with the wr_start edge as cycle 0 and all outputs registered:
  - din_rdy = 1 in cycles L .. L+burst_len−1.
  - dq_out = the din captured at the previous edge, and dq_tri = 0, in cycles L+1 .. L+burst_len.
  - PRE in cycles L−P+1 .. L: dqs_out = 0, dqs_tri = 0.
  - DATA: dqs_out = alternating pattern with even bits 1 and odd bits 0 (for example 4'b0101), dqs_tri = 0.
  - POST in cycles L+burst_len+1 .. L+burst_len+POST_CYCLES: dqs_out = 0, dqs_tri = 0, dq_tri all 1.
- busy = 1 from cycle 1 through the last POST cycle; busy = 0 in the following cycle.
- Outside PRE/DATA/POST: dq_tri and dqs_tri are all 1, and dq_out and dqs_out are 0.
- Width rules:
  - Latency counter is LAT_BITS wide.
  - Data counter is LEN_BITS wide.
  - Counters do not wrap; maximum burst = 2^LEN_BITS − 1 cycles.
- Reset values: dq_out = 0, dq_tri all 1, dqs_out = 0, dqs_tri all 1, din_rdy = 0, busy = 0, err = 0, FSM = IDLE.
- Reset mid-burst aborts the burst; all outputs hold reset values from the cycle after rst is sampled.
- wr_start and rst in the same cycle: reset wins and there is no err.

## Timing
- Request to first data on dq_out: L+1 cycles.
- din to dq_out: 1 cycle.
- No combinational path from any input to any output.
- Back-to-back bursts: the next wr_start is accepted in the first cycle with busy=0. The minimum gap between bursts is therefore 1 idle cycle plus L.

## Configuration
- OSERDES_BURST_POSTAMBLE_EN:
  - Defined: the POST state runs as specified.
  - Undefined: POST is skipped. DATA goes directly to IDLE, dqs_tri returns to all 1 in cycle L+burst_len+1, and busy drops one cycle earlier than the defined case, i.e. immediately after the last DATA cycle.

## Test plan
- NLANES=8, DATA_WIDTH=4, wlat=3, burst_len=2, din = 32'h11111111 then 32'h22222222:
  - din_rdy high in cycles 3–4.
  - dq_out equals those two words in cycles 4–5 with dq_tri = 0.
  - PRE in cycle 3; POST in cycle 6; busy cycles 1–6.
- wlat=0 and PRE_CYCLES=2, burst_len=1: L=1, P=1. Preamble in cycle 1 only; data in cycle 2.
- wr_start while busy, and wr_start with burst_len=0: both ignored, err pulses once each, no output change.
- rst asserted in cycle 4 of the first test: all outputs are reset values in cycle 5; the next wr_start is accepted normally.
- Macro undefined, same stimulus as the first test: dqs_tri = 1 in cycle 6; busy falls in cycle 6.
- Maximum burst_len=15 with wlat=15: no wrap; exactly 15 din_rdy cycles; dq_out lane mapping checked per bit with a walking-one din.
